// File: rtl/bayer_pkg.sv
// Shared types for the Bayer front end: packed quad handed to debayer,
// line-buffer entry and the row-parity FSM state.
package bayer_pkg;

    localparam int PIX_W = 8;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g1;
        logic [PIX_W-1:0] g2;
        logic [PIX_W-1:0] b;
    } quad_t;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g1;
    } lb_entry_t;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } row_state_t;

endpackage

// File: rtl/bayer_quad_builder_if.sv
// Pixel-in / quad-out stream bundle for bayer_quad_builder.
// The slave side is the builder; the master side feeds pixels and drains quads.
interface bayer_quad_builder_if;
    import bayer_pkg::*;

    logic [PIX_W-1:0] in_pixel;
    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    quad_t            out_quad;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;

    modport master (
        output in_pixel, in_valid, in_sof, out_ready,
        input  in_ready, out_quad, out_valid, out_last
    );

    modport slave (
        input  in_pixel, in_valid, in_sof, out_ready,
        output in_ready, out_quad, out_valid, out_last
    );

endinterface

// File: rtl/bayer_line_buf.sv
// Holds the {R, G1} pair of each column pair of the previous even row.
// Write is registered; read is combinational so the odd row can build a quad without extra latency.
module bayer_line_buf
    import bayer_pkg::*;
#(
    parameter int DEPTH = 320,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  lb_entry_t       wdata,
    input  logic [AW-1:0]   raddr,
    output lb_entry_t       rdata
);

    lb_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bayer_quad_builder.sv
// Streams RGGB raw pixels in raster order and emits one {R, G1, G2, B} quad
// per 2x2 cell, at the B sample of each odd row, with one cycle of latency.
module bayer_quad_builder
    import bayer_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    bayer_quad_builder_if.slave   bus
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int DEPTH = IMG_W / 2;
    localparam int AW    = CW - 1;

    logic [CW-1:0]    col, eff_col;
    logic [RW-1:0]    row, eff_row;
    row_state_t       state, eff_state;
    logic [PIX_W-1:0] r_hold, g2_hold;

    quad_t            quad_p1;
    logic             vld_p1;
    logic             last_p1;

    logic             in_ready;
    logic             acc;
    logic             col_end, row_end;
    logic             lb_we, produce;
    logic [AW-1:0]    lb_addr;
    lb_entry_t        lb_wdata, lb_rdata;

    assign in_ready = !(vld_p1 && !bus.out_ready);
    assign acc      = bus.in_valid && in_ready;

    // A start-of-frame sample is placed at row 0, col 0 regardless of where the counters were.
    always_comb begin
        eff_col   = col;
        eff_row   = row;
        eff_state = state;
        if (bus.in_sof) begin
            eff_col   = '0;
            eff_row   = '0;
            eff_state = EVEN_ROW;
        end
    end

    assign col_end  = (eff_col == CW'(IMG_W - 1));
    assign row_end  = (eff_row == RW'(IMG_H - 1));
    assign lb_addr  = eff_col[CW-1:1];
    assign lb_wdata = '{r: r_hold, g1: bus.in_pixel};
    assign lb_we    = acc && eff_col[0] && (eff_state == EVEN_ROW);
    assign produce  = acc && eff_col[0] && (eff_state == ODD_ROW);

    bayer_line_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (lb_wdata),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            state   <= EVEN_ROW;
            r_hold  <= '0;
            g2_hold <= '0;
            quad_p1 <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            if (acc) begin
                if (!eff_col[0]) begin
                    if (eff_state == EVEN_ROW) begin
                        r_hold <= bus.in_pixel;
                    end else begin
                        g2_hold <= bus.in_pixel;
                    end
                end
                if (col_end) begin
                    col   <= '0;
                    row   <= row_end ? '0 : eff_row + RW'(1);
                    state <= (eff_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                end else begin
                    col   <= eff_col + CW'(1);
                    row   <= eff_row;
                    state <= eff_state;
                end
            end
            // Output stage: a new quad can only arrive when the previous one is gone or leaving.
            if (produce) begin
                quad_p1 <= '{r: lb_rdata.r, g1: lb_rdata.g1, g2: g2_hold, b: bus.in_pixel};
                vld_p1  <= 1'b1;
                last_p1 <= row_end && col_end;
            end else if (bus.out_ready) begin
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_quad  = quad_p1;
    assign bus.out_valid = vld_p1;
    assign bus.out_last  = last_p1;

endmodule

// File: tb/tb_bayer_quad_builder.sv
// Bench for bayer_quad_builder on a 4x2 frame: scoreboard of expected {last, quad}
// filled as frames are driven, drained by a monitor on the handshake.
module tb_bayer_quad_builder;
    import bayer_pkg::*;

    typedef logic [7:0] frame_t [8];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [32:0] sb [$];

    bayer_quad_builder_if bus ();

    bayer_quad_builder #(
        .IMG_W (4),
        .IMG_H (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every handshaken quad must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            logic [32:0] exp_v;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_quad: got last=%0b quad=%08h, none expected",
                         bus.out_last, bus.out_quad);
            end else begin
                exp_v = sb.pop_front();
                if ({bus.out_last, 32'(bus.out_quad)} !== exp_v) begin
                    miscompares++;
                    $display("FAIL quad: got last=%0b quad=%08h, expected last=%0b quad=%08h",
                             bus.out_last, bus.out_quad, exp_v[32], exp_v[31:0]);
                end
            end
        end
    end

    task automatic push_frame(input frame_t f);
        for (int k = 0; k < 2; k++) begin
            sb.push_back({(k == 1), f[2*k], f[2*k+1], f[4+2*k], f[5+2*k]});
        end
    endtask

    task automatic send_pix(input logic [7:0] p, input logic sof);
        int n = 0;
        bus.in_pixel = p;
        bus.in_sof   = sof;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, expected 1", bus.in_ready, n);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_range(input frame_t f, input int first, input int last_i,
                              input logic sof_first, input int max_gap);
        for (int i = first; i <= last_i; i++) begin
            send_pix(f[i], sof_first && (i == first));
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d quads outstanding, out_valid=%0b, expected 0 and 0",
                     name, sb.size(), bus.out_valid);
        end
        #1;
        sb.delete();
    endtask

    function automatic logic [31:0] debayer(input logic [31:0] q);
        logic [8:0] s;
        s = {1'b0, q[23:16]} + {1'b0, q[15:8]};
        return {8'hFF, q[31:24], s[8:1], q[7:0]};
    endfunction

    frame_t f_basic = '{8'h38, 8'h21, 8'h40, 8'h22, 8'h23, 8'hAB, 8'h24, 8'hBC};

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %0b, expected 0", bus.out_valid);
        end
        vectors++;
        if (bus.out_last !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_last: got %0b, expected 0", bus.out_last);
        end
        vectors++;
        if (bus.out_quad !== 32'h0) begin
            miscompares++; $display("FAIL reset_out_quad: got %08h, expected 00000000", bus.out_quad);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %0b, expected 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        sb.push_back({1'b0, 32'h3821_23AB});
        sb.push_back({1'b1, 32'h4022_24BC});
        send_range(f_basic, 0, 7, 1'b1, 0);
        drain("basic");
    endtask

    task automatic test_backpressure();
        sb.push_back({1'b0, 32'h3821_23AB});
        sb.push_back({1'b1, 32'h4022_24BC});
        send_range(f_basic, 0, 6, 1'b1, 0);
        bus.out_ready = 1'b0;
        send_pix(f_basic[7], 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_in_ready: cycle %0d got %0b, expected 0", c, bus.in_ready);
            end
            vectors++;
            if ({bus.out_valid, bus.out_last, 32'(bus.out_quad)} !== {2'b11, 32'h4022_24BC}) begin
                miscompares++;
                $display("FAIL bp_hold: cycle %0d got v=%0b l=%0b q=%08h, expected v=1 l=1 q=402224BC",
                         c, bus.out_valid, bus.out_last, bus.out_quad);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_release_in_ready: got %0b, expected 1", bus.in_ready);
        end
        drain("backpressure");
    endtask

    task automatic test_sof_resync();
        frame_t fa = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        frame_t fb = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
        sb.push_back({1'b0, 32'h1011_1415});
        sb.push_back({1'b0, 32'h5051_5455});
        sb.push_back({1'b1, 32'h5253_5657});
        send_range(fa, 0, 5, 1'b1, 0);
        send_range(fb, 0, 7, 1'b1, 0);
        drain("sof_resync");
    endtask

    task automatic test_reset_midframe();
        frame_t fc = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
        send_range(f_basic, 0, 4, 1'b1, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.out_last, 32'(bus.out_quad)} !== 34'h0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got v=%0b l=%0b q=%08h, expected all 0",
                     bus.out_valid, bus.out_last, bus.out_quad);
        end
        @(posedge clk);
        #1;
        push_frame(fc);
        send_range(fc, 0, 7, 1'b0, 0);
        drain("reset_midframe");
    endtask

    task automatic test_gaps();
        frame_t fd;
        for (int i = 0; i < 8; i++) fd[i] = 8'($urandom);
        push_frame(fd);
        send_range(fd, 0, 7, 1'b1, 3);
        push_frame(fd);
        send_range(fd, 0, 7, 1'b1, 0);
        drain("gaps");
    endtask

    task automatic test_back_to_back();
        frame_t fe = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        frame_t ff = '{8'hC8, 8'hC9, 8'hCA, 8'hCB, 8'hCC, 8'hCD, 8'hCE, 8'hCF};
        push_frame(fe);
        push_frame(ff);
        send_range(fe, 0, 7, 1'b1, 0);
        send_range(ff, 0, 7, 1'b0, 0);
        drain("back_to_back");
    endtask

    task automatic test_debayer_chain();
        logic [31:0] q;
        sb.push_back({1'b0, 32'h3821_23AB});
        sb.push_back({1'b1, 32'h4022_24BC});
        send_range(f_basic, 0, 5, 1'b1, 0);
        q = bus.out_quad;
        vectors++;
        if (bus.out_valid !== 1'b1) begin
            miscompares++; $display("FAIL chain_latency: out_valid=%0b one cycle after B, expected 1", bus.out_valid);
        end
        vectors++;
        if (debayer(q) !== 32'hFF38_22AB) begin
            miscompares++; $display("FAIL chain_debayer: got %08h, expected FF3822AB", debayer(q));
        end
        send_range(f_basic, 6, 7, 1'b0, 0);
        drain("debayer_chain");
    endtask

    initial begin
        bus.in_pixel  = '0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_sof_resync();
        test_reset_midframe();
        test_gaps();
        test_back_to_back();
        test_debayer_chain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
